xadac_dispatch: RTL
===================

Name: xadac_dispatch

Overview:
- Initiator (master) end of the xadac_if protocol. It accepts one custom-opcode instruction at a time from the core side, runs the dec handshake, and reads vs1/vs2/vd from a vector register file.
- It then issues the exe request, collects the exe response and writes the result back to the VRF.
- It is the counterpart that drives any xadac_if.slv responder, for example the vmacc unit.
- One instruction is in flight at a time, and there is no scoreboard.

Parameters:
- TimeoutCycles, 256, watchdog limit in cycles. Used only with XADAC_DISPATCH_TIMEOUT_EN.
- VRF geometry, fixed: 32 registers of VecDataWidth bits.
- VecDataWidth and IdT come from xadac_pkg.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- instr_valid  in  1  upstream instruction valid
- instr_ready  out  1  block can accept an instruction
- instr  in  32  instruction word
- instr_id  in  IdT  instruction tag
- rs1_data  in  32  scalar operand, sampled with instr
- rs2_data  in  32  scalar operand, sampled with instr
- mst  modport  xadac_if.mst  dec and exe channels toward the responder
- vrf_raddr[3]  out  3x5  VRF read addresses: [0]=vs1, [1]=vs2, [2]=vd
- vrf_rdata[3]  in  3xVecDataWidth  synchronous VRF read data, valid the cycle after the address
- vrf_we  out  1  VRF write enable (one-cycle pulse)
- vrf_waddr  out  5  VRF write address
- vrf_wdata  out  VecDataWidth  VRF write data
- rejected  out  1  pulse: responder returned accept=0
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rstn low, asynchronous):
  - State goes to IDLE.
  - All outputs and the operand/instruction registers go to 0, except instr_ready=1.
  - Reset mid-operation drops the instruction in flight with no VRF write.
- States: IDLE -> DEC -> RD -> CAP -> EXE -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch instr, instr_id and rs1/rs2_data, then go to DEC.
- DEC:
  - Drive dec_req_valid=1 with dec_req.id = latched id and dec_req.instr = latched instr.
  - Drive dec_rsp_ready=1.
  - The handshake completes in the cycle where dec_req_valid, dec_req_ready and dec_rsp_valid are all 1. A combinational responder completes it in the same cycle.
  - On completion, latch dec_rsp.rs_read, vs_read and accept.
  - If accept=0: pulse rejected for one cycle and go to IDLE. No exe request is issued.
  - If accept=1: go to RD.
- RD:
  - vrf_raddr[0] = instr[19:15], vrf_raddr[1] = instr[24:20], vrf_raddr[2] = instr[11:7].
  - Go to CAP.
- CAP:
  - Latch vrf_rdata[k] if vs_read[k]=1, otherwise latch 0.
  - Latch rs_data[0..1] = rs1/rs2_data if rs_read[k]=1, otherwise 0.
  - Go to EXE.
- EXE:
  - Drive exe_req_valid=1 with id, instr, the latched vs_data[0..2] and rs_data; all fields stay stable until the handshake.
  - Drive exe_rsp_ready=1.
  - The handshake is exe_req_valid & exe_req_ready & exe_rsp_valid.
  - On the handshake, latch exe_rsp.vd_write, vd_addr and vd_data, then go to WB.
- WB:
  - vrf_we = latched vd_write, vrf_waddr = vd_addr, vrf_wdata = vd_data.
  - Go to IDLE.
- Outside their state, dec_req_valid, exe_req_valid, dec_rsp_ready and exe_rsp_ready are 0.
- Latency with a zero-wait responder:
  - instr handshake at cycle T, dec completes at T+1, exe completes at T+4, vrf_we at T+5.
  - instr_ready is high again at T+6, so throughput is one instruction per 6 cycles.
- Back-pressure: any number of cycles may be spent in DEC or EXE. Requests stay asserted and stable throughout.
- Mismatched ids: an exe_rsp.id that does not match the latched id is ignored for state purposes. Only the handshake matters.

Optional Feature:
- Macro: XADAC_DISPATCH_TIMEOUT_EN.
- When defined:
  - A counter clears on every state entry and counts cycles spent in DEC or EXE.
  - When it reaches TimeoutCycles, deassert the requests, pulse the output port timeout (1 bit, reset 0) and go to IDLE with no VRF write.
- When undefined: there is no counter and no timeout port, and the block waits indefinitely.

Test Plan:
- Zero-wait vmacc responder:
  - Set VRF v1 = 0x01 bytes, v2 = 0x02 bytes, v3 = 0; issue vmacc with vd=3, vs1=1, vs2=2.
  - Expect vrf_we at T+5 with waddr=3 and each 32-bit lane = 2*jlen.
- accept=0 responder:
  - Expect a one-cycle rejected pulse at T+1, no exe_req_valid, no vrf_we, and instr_ready high at T+2.
- Responder holding dec_rsp_valid low for 7 cycles, then exe_rsp_valid low for 5 cycles:
  - Requests stay stable throughout.
  - vrf_we occurs exactly 1 cycle after the exe handshake.
- vs_read = {1,0,1} and rs_read = {1,0}:
  - exe_req.vs_data[1] = 0 and rs_data[1] = 0.
  - The other operands match the VRF and rs1 values.
- rstn asserted while in EXE:
  - All outputs go to reset values immediately (asynchronously).
  - No vrf_we, and the next instruction is processed normally.
- With XADAC_DISPATCH_TIMEOUT_EN and TimeoutCycles=16, responder never acknowledging exe:
  - timeout pulses after 16 cycles in EXE, the block returns to IDLE, and there is no vrf_we.

Source files
------------

// File: rtl/xadac_pkg.sv
// xadac_pkg: shared widths and channel payload types for the xadac_if
// decode/execute protocol between a dispatcher and a custom-opcode responder.
package xadac_pkg;

    localparam int VecDataWidth = 128;

    typedef logic [3:0] IdT;

    typedef struct packed {
        IdT          id;
        logic [31:0] instr;
    } dec_req_t;

    typedef struct packed {
        IdT         id;
        logic [1:0] rs_read;
        logic [2:0] vs_read;
        logic       accept;
    } dec_rsp_t;

    typedef struct packed {
        IdT                           id;
        logic [31:0]                  instr;
        logic [2:0][VecDataWidth-1:0] vs_data;
        logic [1:0][31:0]             rs_data;
    } exe_req_t;

    typedef struct packed {
        IdT                      id;
        logic [4:0]              vd_addr;
        logic [VecDataWidth-1:0] vd_data;
        logic                    vd_write;
    } exe_rsp_t;

endpackage

// File: rtl/xadac_if.sv
// xadac_if: dec and exe request/response channels; mst drives requests,
// slv answers them.
interface xadac_if;
    import xadac_pkg::*;

    logic     dec_req_valid;
    logic     dec_req_ready;
    dec_req_t dec_req;
    logic     dec_rsp_valid;
    logic     dec_rsp_ready;
    dec_rsp_t dec_rsp;

    logic     exe_req_valid;
    logic     exe_req_ready;
    exe_req_t exe_req;
    logic     exe_rsp_valid;
    logic     exe_rsp_ready;
    exe_rsp_t exe_rsp;

    modport mst (
        output dec_req_valid, dec_req, dec_rsp_ready,
        output exe_req_valid, exe_req, exe_rsp_ready,
        input  dec_req_ready, dec_rsp_valid, dec_rsp,
        input  exe_req_ready, exe_rsp_valid, exe_rsp
    );

    modport slv (
        input  dec_req_valid, dec_req, dec_rsp_ready,
        input  exe_req_valid, exe_req, exe_rsp_ready,
        output dec_req_ready, dec_rsp_valid, dec_rsp,
        output exe_req_ready, exe_rsp_valid, exe_rsp
    );

endinterface

// File: rtl/xadac_dispatch.sv
// xadac_dispatch: xadac_if initiator; one instruction in flight through
// dec, VRF operand fetch, exe and VRF writeback. Watchdog: XADAC_DISPATCH_TIMEOUT_EN.
module xadac_dispatch
    import xadac_pkg::*;
`ifdef XADAC_DISPATCH_TIMEOUT_EN
    #(parameter int TimeoutCycles = 256)
`endif
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [31:0]             instr,
    input  IdT                      instr_id,
    input  logic [31:0]             rs1_data,
    input  logic [31:0]             rs2_data,
    xadac_if.mst                    mst,
    output logic [4:0]              vrf_raddr [3],
    input  logic [VecDataWidth-1:0] vrf_rdata [3],
    output logic                    vrf_we,
    output logic [4:0]              vrf_waddr,
    output logic [VecDataWidth-1:0] vrf_wdata,
    output logic                    rejected,
    output logic                    busy
`ifdef XADAC_DISPATCH_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);

    typedef enum logic [2:0] {IDLE, DEC, RD, CAP, EXE, WB} state_e;

    state_e state_q, state_d;

    logic [31:0]                  instr_q;
    IdT                           id_q;
    logic [31:0]                  rs1_q, rs2_q;
    logic [1:0]                   rs_read_q;
    logic [2:0]                   vs_read_q;
    logic [2:0][VecDataWidth-1:0] vs_data_q;
    logic [1:0][31:0]             rs_data_q;
    logic                         vd_write_q;
    logic [4:0]                   vd_addr_q;
    logic [VecDataWidth-1:0]      vd_data_q;

    logic expired;
    logic in_dec, in_exe, dec_fire, exe_fire;

    // A wait that hits the watchdog drops its request in that same cycle.
    assign in_dec   = (state_q == DEC) && !expired;
    assign in_exe   = (state_q == EXE) && !expired;
    assign dec_fire = in_dec && mst.dec_req_ready && mst.dec_rsp_valid;
    assign exe_fire = in_exe && mst.exe_req_ready && mst.exe_rsp_valid;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d           = state_q;
        instr_ready       = 1'b0;
        rejected          = 1'b0;
        mst.dec_req_valid = in_dec;
        mst.dec_rsp_ready = in_dec;
        mst.exe_req_valid = in_exe;
        mst.exe_rsp_ready = in_exe;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = DEC;
            end
            DEC: begin
                if (expired) begin
                    state_d = IDLE;
                end else if (dec_fire) begin
                    rejected = !mst.dec_rsp.accept;
                    state_d  = mst.dec_rsp.accept ? RD : IDLE;
                end
            end
            RD:  state_d = CAP;
            CAP: state_d = EXE;
            EXE: begin
                if (expired || exe_fire) state_d = expired ? IDLE : WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request payloads come straight from the latched fields, so they hold
    // steady for as long as the responder stalls.
    assign mst.dec_req = '{id: id_q, instr: instr_q};
    assign mst.exe_req = '{id: id_q, instr: instr_q, vs_data: vs_data_q, rs_data: rs_data_q};

    assign vrf_raddr[0] = instr_q[19:15];
    assign vrf_raddr[1] = instr_q[24:20];
    assign vrf_raddr[2] = instr_q[11:7];

    assign vrf_we    = (state_q == WB) && vd_write_q;
    assign vrf_waddr = vd_addr_q;
    assign vrf_wdata = vd_data_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            id_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs_read_q  <= '0;
            vs_read_q  <= '0;
            vs_data_q  <= '0;
            rs_data_q  <= '0;
            vd_write_q <= 1'b0;
            vd_addr_q  <= '0;
            vd_data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
            state_q <= state_d;
            case (state_q)
                IDLE: if (instr_valid) begin
                    instr_q <= instr;
                    id_q    <= instr_id;
                    rs1_q   <= rs1_data;
                    rs2_q   <= rs2_data;
                end
                DEC: if (dec_fire) begin
                    rs_read_q <= mst.dec_rsp.rs_read;
                    vs_read_q <= mst.dec_rsp.vs_read;
                end
                CAP: begin
                    for (int k = 0; k < 3; k++)
                        vs_data_q[k] <= vs_read_q[k] ? vrf_rdata[k] : '0;
                    rs_data_q[0] <= rs_read_q[0] ? rs1_q : '0;
                    rs_data_q[1] <= rs_read_q[1] ? rs2_q : '0;
                end
                EXE: if (exe_fire) begin
                    vd_write_q <= mst.exe_rsp.vd_write;
                    vd_addr_q  <= mst.exe_rsp.vd_addr;
                    vd_data_q  <= mst.exe_rsp.vd_data;
                end
                default: ;
            endcase
        end
    end

`ifdef XADAC_DISPATCH_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] wait_cnt_q;

    // Cleared on every state change; only DEC and EXE accumulate wait cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wait_cnt_q <= '0;
        else if (state_d != state_q)
            wait_cnt_q <= '0;
        else if (state_q == DEC || state_q == EXE)
            wait_cnt_q <= wait_cnt_q + CntW'(1);
    end

    assign expired = (state_q == DEC || state_q == EXE) && (wait_cnt_q == CntW'(TimeoutCycles));
    assign timeout = expired;
`else
    assign expired = 1'b0;
`endif

endmodule
